// File: rtl/clocked_pulse_merger.sv
// Two-input merger for toggle-encoded pulses with a saturating pending-pulse counter.
// Define COLLISION_STATS_EN to add the collisions port and counter.
module clocked_pulse_merger #(
  parameter int CNT_W         = 4,
  parameter int WARMUP_CYCLES = 8,
  parameter int STAT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1,
  input  logic             in2,
  output logic             out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
`ifdef COLLISION_STATS_EN
  output logic [STAT_W-1:0] collisions,
`endif
  output logic             overflow
);

  localparam int W1   = CNT_W + 1;
  localparam int WU_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [W1-1:0] MAX = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t          state;
  logic [WU_W-1:0] wu_cnt;
  logic            primed;
  logic            s1, s2, q1, q2;

  logic            d1, d2, e;
  logic [1:0]      a;
  logic [W1-1:0]   sum, t;

  always_comb begin
    d1  = s1 ^ q1;
    d2  = s2 ^ q2;
    a   = {1'b0, d1} + {1'b0, d2};
    sum = {1'b0, pending} + W1'(a);
    e   = (sum != '0);
    // t needs the extra bit so pending+2 at MAX is visible before clamping
    t   = sum - W1'(e);
  end

  assign busy = (state == RUN) && (pending != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WARMUP;
      wu_cnt   <= '0;
      primed   <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      q1       <= 1'b0;
      q2       <= 1'b0;
      out      <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
`ifdef COLLISION_STATS_EN
      collisions <= '0;
`endif
    end else if (!primed) begin
      // load history from the live level so a held-high input is not a pulse
      primed <= 1'b1;
      s1     <= in1;
      s2     <= in2;
      q1     <= in1;
      q2     <= in2;
    end else begin
      s1 <= in1;
      s2 <= in2;
      q1 <= s1;
      q2 <= s2;
      case (state)
        WARMUP: begin
          if (wu_cnt == WU_W'(WARMUP_CYCLES)) begin
            state <= RUN;
          end else begin
            wu_cnt <= wu_cnt + WU_W'(1);
          end
        end
        RUN: begin
          out <= out ^ e;
          if (t > MAX) begin
            pending  <= MAX[CNT_W-1:0];
            overflow <= 1'b1;
          end else begin
            pending <= t[CNT_W-1:0];
          end
`ifdef COLLISION_STATS_EN
          if (d1 && d2 && (collisions != '1)) begin
            collisions <= collisions + STAT_W'(1);
          end
`endif
        end
        default: state <= WARMUP;
      endcase
    end
  end

endmodule

// File: tb/tb_clocked_pulse_merger.sv
// Directed bench: instance a (CNT_W=2, warmup 8), instance b (CNT_W=4, warmup 0).
// Expected values are hand-derived from the pending-counter update rule.
module tb_clocked_pulse_merger;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_in1 = 1'b0, a_in2 = 1'b0;
  logic b_in1 = 1'b1, b_in2 = 1'b0;
  logic a_out, a_busy, a_ovf;
  logic b_out, b_busy, b_ovf;
  logic [1:0] a_pend;
  logic [3:0] b_pend;
`ifdef COLLISION_STATS_EN
  logic [7:0] a_coll, b_coll;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clocked_pulse_merger #(.CNT_W(2), .WARMUP_CYCLES(8), .STAT_W(8)) u_a (
    .clk(clk), .rst(rst), .in1(a_in1), .in2(a_in2),
    .out(a_out), .pending(a_pend), .busy(a_busy),
`ifdef COLLISION_STATS_EN
    .collisions(a_coll),
`endif
    .overflow(a_ovf)
  );

  clocked_pulse_merger #(.CNT_W(4), .WARMUP_CYCLES(0), .STAT_W(8)) u_b (
    .clk(clk), .rst(rst), .in1(b_in1), .in2(b_in2),
    .out(b_out), .pending(b_pend), .busy(b_busy),
`ifdef COLLISION_STATS_EN
    .collisions(b_coll),
`endif
    .overflow(b_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({a_out, a_pend, a_busy, a_ovf} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_a got %b want 00000", {a_out, a_pend, a_busy, a_ovf});
    end
    n_cmp++;
    if ({b_out, b_pend, b_busy, b_ovf} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_b got %b want 0000000", {b_out, b_pend, b_busy, b_ovf});
    end
`ifdef COLLISION_STATS_EN
    n_cmp++;
    if (a_coll !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_coll got %0d want 0", a_coll);
    end
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_warmup();
    repeat (3) tick();
    a_in1 = 1'b1;
    repeat (9) tick();
    n_cmp++;
    if (a_out !== 1'b0) begin
      n_bad++;
      $display("FAIL warmup_out got %b want 0", a_out);
    end
    n_cmp++;
    if (a_pend !== 2'd0 || a_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL warmup_pend got %0d/%b want 0/0", a_pend, a_busy);
    end
  endtask

  task automatic test_single();
    a_in1 = ~a_in1;
    tick();
    n_cmp++;
    if (a_out !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early got %b want 0", a_out);
    end
    tick();
    n_cmp++;
    if (a_out !== 1'b1 || a_pend !== 2'd0) begin
      n_bad++;
      $display("FAIL single_toggle got %b/%0d want 1/0", a_out, a_pend);
    end
    tick();
    n_cmp++;
    if (a_out !== 1'b1) begin
      n_bad++;
      $display("FAIL single_hold got %b want 1", a_out);
    end
  endtask

  task automatic test_coincident();
    a_in1 = ~a_in1;
    a_in2 = ~a_in2;
    tick();
    n_cmp++;
    if (a_out !== 1'b1) begin
      n_bad++;
      $display("FAIL coinc_k got %b want 1", a_out);
    end
    tick();
    n_cmp++;
    if ({a_out, a_pend, a_busy} !== 4'b0011) begin
      n_bad++;
      $display("FAIL coinc_k1 got %b want 0011", {a_out, a_pend, a_busy});
    end
    tick();
    n_cmp++;
    if ({a_out, a_pend, a_busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL coinc_k2 got %b want 1000", {a_out, a_pend, a_busy});
    end
`ifdef COLLISION_STATS_EN
    n_cmp++;
    if (a_coll !== 8'd1) begin
      n_bad++;
      $display("FAIL coinc_coll got %0d want 1", a_coll);
    end
`endif
  endtask

  task automatic test_saturation();
    int   toggles = 0;
    logic prev    = a_out;
    for (int i = 0; i < 4; i++) begin
      a_in1 = ~a_in1;
      a_in2 = ~a_in2;
      tick();
      if (a_out !== prev) toggles++;
      prev = a_out;
    end
    n_cmp++;
    if (a_pend !== 2'd3 || a_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_fill got %0d/%b want 3/0", a_pend, a_ovf);
    end
    tick();
    if (a_out !== prev) toggles++;
    prev = a_out;
    n_cmp++;
    if (a_pend !== 2'd3 || a_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_clamp got %0d/%b want 3/1", a_pend, a_ovf);
    end
    repeat (6) begin
      tick();
      if (a_out !== prev) toggles++;
      prev = a_out;
    end
    n_cmp++;
    if (toggles != 7) begin
      n_bad++;
      $display("FAIL sat_toggles got %0d want 7", toggles);
    end
    n_cmp++;
    if (a_pend !== 2'd0 || a_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_drain got %0d/%b want 0/1", a_pend, a_ovf);
    end
`ifdef COLLISION_STATS_EN
    n_cmp++;
    if (a_coll !== 8'd5) begin
      n_bad++;
      $display("FAIL sat_coll got %0d want 5", a_coll);
    end
`endif
  endtask

  task automatic test_level_through_reset();
    n_cmp++;
    if (b_out !== 1'b0 || b_pend !== 4'd0) begin
      n_bad++;
      $display("FAIL level_b got %b/%0d want 0/0", b_out, b_pend);
    end
    b_in1 = 1'b0;
    tick();
    n_cmp++;
    if (b_out !== 1'b0) begin
      n_bad++;
      $display("FAIL level_b_early got %b want 0", b_out);
    end
    tick();
    n_cmp++;
    if (b_out !== 1'b1) begin
      n_bad++;
      $display("FAIL level_b_toggle got %b want 1", b_out);
    end
  endtask

  task automatic test_reset_midflight();
    int   toggles = 0;
    logic prev;
    for (int i = 0; i < 3; i++) begin
      a_in1 = ~a_in1;
      a_in2 = ~a_in2;
      tick();
    end
    tick();
    n_cmp++;
    if (a_pend !== 2'd3) begin
      n_bad++;
      $display("FAIL mid_pend got %0d want 3", a_pend);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_out, a_pend, a_busy, a_ovf} !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_reset got %b want 00000", {a_out, a_pend, a_busy, a_ovf});
    end
    tick();
    tick();
    rst  = 1'b0;
    prev = a_out;
    repeat (15) begin
      tick();
      if (a_out !== prev) toggles++;
      prev = a_out;
    end
    n_cmp++;
    if (toggles != 0 || a_pend !== 2'd0) begin
      n_bad++;
      $display("FAIL mid_after got %0d/%0d want 0/0", toggles, a_pend);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_single();
    test_coincident();
    test_saturation();
    test_level_through_reset();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
